// File: rtl/s_axi4l_pkg.sv
// s_axi4l_pkg: shared sizes, address map and types for the SNN AXI4-Lite slave.
package s_axi4l_pkg;
    localparam int N               = 256;
    localparam int M               = $clog2(N);
    localparam int AXI_DATA_WIDTH  = 32;
    localparam int AXI_ADDR_WIDTH  = 32;
    localparam int IMAGE_SIZE      = 256;
    localparam int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE);
    localparam int PIXEL_MAX_VALUE = 255;
    localparam int PIXEL_BITS      = $clog2(PIXEL_MAX_VALUE);
    localparam int ADDR_RESULT     = 0;
    localparam int ADDR_CTRL       = IMAGE_SIZE;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    typedef logic [PIXEL_BITS-1:0] pixel_t;
endpackage

// File: rtl/s_axi4l_interface.sv
// s_axi4l_interface: AXI4-Lite slave holding the SNN input image and control bit,
// and returning the inferred digit on reads.
module s_axi4l_interface
    import s_axi4l_pkg::*;
(
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic [AXI_ADDR_WIDTH-1:0]   AWADDR,
    input  logic [2:0]                  AWPROT,
    input  logic                        AWVALID,
    output logic                        AWREADY,
    input  logic [AXI_DATA_WIDTH-1:0]   WDATA,
    input  logic [3:0]                  WSTRB,
    input  logic                        WVALID,
    output logic                        WREADY,
    output logic [1:0]                  BRESP,
    output logic                        BVALID,
    input  logic                        BREADY,
    input  logic [AXI_ADDR_WIDTH-1:0]   ARADDR,
    input  logic [2:0]                  ARPROT,
    input  logic                        ARVALID,
    output logic                        ARREADY,
    output logic [AXI_DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]                  RRESP,
    output logic                        RVALID,
    input  logic                        RREADY,
    input  logic [M-1:0]                INFERED_DIGIT,
    output logic [PIXEL_BITS-1:0]       IMAGE [0:IMAGE_SIZE-1],
    output logic                        NEW_IMAGE
);
    pixel_t                      r_pixels [0:IMAGE_SIZE-1];
    logic                        r_ctrl;
    logic                        r_awready;
    logic                        r_bvalid;
    logic                        r_arready;
    logic                        r_rvalid;
    logic [AXI_DATA_WIDTH-1:0]   r_rdata;
    logic                        w_wr_go;
    logic                        w_rd_go;
    logic [AXI_DATA_WIDTH-1:0]   w_rd_data;
    logic                        w_unused;

    assign w_unused = ^{AWPROT, ARPROT, WSTRB[3:1], WDATA[AXI_DATA_WIDTH-1:PIXEL_BITS]};

    // Both address and data must be present; the write commits on the accepting edge.
    assign w_wr_go = AWVALID && WVALID && !r_bvalid && !r_awready;
    assign w_rd_go = ARVALID && !r_rvalid && !r_arready;

    assign w_rd_data = (ARADDR == ADDR_RESULT) ? {{(AXI_DATA_WIDTH-M){1'b0}}, INFERED_DIGIT} :
                       (ARADDR == ADDR_CTRL)   ? {{(AXI_DATA_WIDTH-1){1'b0}}, r_ctrl} : '0;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_awready <= 1'b0;
            r_bvalid  <= 1'b0;
            r_ctrl    <= 1'b0;
            for (int i = 0; i < IMAGE_SIZE; i++) r_pixels[i] <= '0;
        end else begin
            r_awready <= w_wr_go;
            r_bvalid  <= r_awready || (r_bvalid && !BREADY);
            if (w_wr_go && WSTRB[0]) begin
                if (AWADDR < IMAGE_SIZE)
                    r_pixels[AWADDR[IMAGE_SIZE_BITS-1:0]] <= WDATA[PIXEL_BITS-1:0];
                else if (AWADDR == ADDR_CTRL)
                    r_ctrl <= WDATA[0];
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_arready <= w_rd_go;
            r_rvalid  <= r_arready || (r_rvalid && !RREADY);
            r_rdata   <= w_rd_go ? w_rd_data : r_rdata;
        end
    end

    assign AWREADY   = r_awready;
    assign WREADY    = r_awready;
    assign BVALID    = r_bvalid;
    assign BRESP     = RESP_OKAY;
    assign ARREADY   = r_arready;
    assign RVALID    = r_rvalid;
    assign RDATA     = r_rdata;
    assign RRESP     = RESP_OKAY;
    assign IMAGE     = r_pixels;
    assign NEW_IMAGE = r_ctrl;
endmodule

// File: tb/tb_s_axi4l_interface.sv
// tb_s_axi4l_interface: randomized AXI4-Lite traffic checked against an array model
// of the pixel memory, control bit and read map.
module tb_s_axi4l_interface;
    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [2:0]  AWPROT, ARPROT;
    logic [3:0]  WSTRB;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY, NEW_IMAGE;
    logic [1:0]  BRESP, RRESP;
    logic [7:0]  INFERED_DIGIT;
    logic [7:0]  IMAGE [0:255];

    logic [7:0]  m_img [0:255];
    logic        m_ctrl;
    int          errors = 0;
    int          checks = 0;

    always #5 ACLK = ~ACLK;

    s_axi4l_interface dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .INFERED_DIGIT(INFERED_DIGIT), .IMAGE(IMAGE), .NEW_IMAGE(NEW_IMAGE)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_image(input string tag);
        for (int i = 0; i < 256; i++) check($sformatf("%s_px%0d", tag, i), IMAGE[i], m_img[i]);
        check({tag, "_new_image"}, NEW_IMAGE, m_ctrl);
    endtask

    function automatic logic [31:0] read_model(input logic [31:0] addr);
        return addr == 0 ? {24'd0, INFERED_DIGIT} : addr == 256 ? {31'd0, m_ctrl} : 32'd0;
    endfunction

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int hold, input bit poke);
        int n = 0;
        AWADDR = addr; WDATA = data; WSTRB = strb; AWVALID = 1; WVALID = 1;
        do begin @(posedge ACLK); #1; n++; end while (!AWREADY && n < 20);
        check("awready_seen", AWREADY, 1);
        check("wready_with_awready", WREADY, 1);
        @(posedge ACLK); #1;
        AWVALID = 0; WVALID = 0;
        check("awready_pulse", AWREADY, 0);
        if (strb[0]) begin
            if (addr < 256) m_img[addr[7:0]] = data[7:0];
            else if (addr == 256) m_ctrl = data[0];
        end
        n = 0;
        while (!BVALID && n < 20) begin @(posedge ACLK); #1; n++; end
        check("bvalid_seen", BVALID, 1);
        check("bresp", BRESP, 0);
        for (int k = 0; k < hold; k++) begin
            if (poke) begin AWADDR = 0; WDATA = 32'hAA; WSTRB = 4'hF; AWVALID = 1; WVALID = 1; end
            @(posedge ACLK); #1;
            check("bvalid_hold", BVALID, 1);
            check("aw_blocked", AWREADY, 0);
        end
        AWVALID = 0; WVALID = 0;
        BREADY = 1; @(posedge ACLK); #1; BREADY = 0;
        check("bvalid_clear", BVALID, 0);
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp,
                            input int hold, input bit poke);
        int n = 0;
        ARADDR = addr; ARVALID = 1;
        do begin @(posedge ACLK); #1; n++; end while (!ARREADY && n < 20);
        check("arready_seen", ARREADY, 1);
        @(posedge ACLK); #1;
        ARVALID = 0;
        check("arready_pulse", ARREADY, 0);
        n = 0;
        while (!RVALID && n < 20) begin @(posedge ACLK); #1; n++; end
        check("rvalid_seen", RVALID, 1);
        check($sformatf("rdata_a%0d", addr), RDATA, exp);
        check("rresp", RRESP, 0);
        for (int k = 0; k < hold; k++) begin
            if (poke) begin ARADDR = 256; ARVALID = 1; end
            @(posedge ACLK); #1;
            check("rvalid_hold", RVALID, 1);
            check("rdata_stable", RDATA, exp);
            check("ar_blocked", ARREADY, 0);
        end
        ARVALID = 0;
        RREADY = 1; @(posedge ACLK); #1; RREADY = 0;
        check("rvalid_clear", RVALID, 0);
    endtask

    initial begin
        logic [31:0] a, d, e;
        ARESET = 1; AWADDR = 0; AWPROT = 0; AWVALID = 0; WDATA = 0; WSTRB = 0; WVALID = 0;
        BREADY = 0; ARADDR = 0; ARPROT = 0; ARVALID = 0; RREADY = 0; INFERED_DIGIT = 0;
        m_ctrl = 0;
        for (int i = 0; i < 256; i++) m_img[i] = 0;
        repeat (3) @(posedge ACLK);
        #1;
        check("rst_awready", AWREADY, 0);
        check("rst_wready", WREADY, 0);
        check("rst_bvalid", BVALID, 0);
        check("rst_arready", ARREADY, 0);
        check("rst_rvalid", RVALID, 0);
        check("rst_rdata", RDATA, 0);
        check_image("rst");
        @(negedge ACLK); ARESET = 0;

        for (int i = 0; i < 256; i++) begin
            d = (i == 56) ? 3 : (i == 57) ? 32 : (i == 58) ? 81 : $urandom_range(0, 255);
            axi_write(i, d | ($urandom & 32'hFFFF_FF00), 4'h1, $urandom_range(0, 2), 0);
            check($sformatf("px_write%0d", i), IMAGE[i], d);
            #8;
        end
        check_image("load");

        axi_write(256, 1, 4'h1, 0, 0);
        check_image("ctrl_set");
        axi_write(256, 0, 4'h1, 0, 0);
        check_image("ctrl_clr");

        INFERED_DIGIT = 5;
        axi_read(0, 32'h5, 4, 1);
        axi_write(7, 32'h11, 4'h1, 4, 1);
        check_image("poke_write");

        axi_write(300, 32'hFF, 4'h1, 1, 0);
        axi_write(10, 32'h77, 4'h0, 1, 0);
        check_image("ignored_writes");
        axi_read(300, 0, 1, 0);
        axi_read(10, 0, 0, 0);

        INFERED_DIGIT = 8'd201;
        fork
            axi_write(20, 32'h5A, 4'h1, 1, 0);
            axi_read(0, 32'd201, 2, 0);
        join
        check_image("concurrent");

        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 3))
                0: a = $urandom_range(0, 255);
                1: a = 256;
                2: a = 257 + $urandom_range(0, 5000);
                default: a = $urandom | 32'h0001_0000;
            endcase
            if ($urandom_range(0, 1) == 1) begin
                axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2), 0);
                check_image($sformatf("rnd%0d", it));
            end else begin
                if (a[1]) a = 0;
                INFERED_DIGIT = 8'($urandom);
                e = read_model(a);
                axi_read(a, e, $urandom_range(0, 2), 0);
            end
        end

        AWADDR = 5; WDATA = 9; WSTRB = 1; AWVALID = 1; WVALID = 1; ARADDR = 256; ARVALID = 1;
        @(posedge ACLK); #3;
        ARESET = 1; #1;
        for (int i = 0; i < 256; i++) m_img[i] = 0;
        m_ctrl = 0;
        check("midrst_awready", AWREADY, 0);
        check("midrst_arready", ARREADY, 0);
        check("midrst_bvalid", BVALID, 0);
        check("midrst_rvalid", RVALID, 0);
        check_image("midrst");
        AWVALID = 0; WVALID = 0; ARVALID = 0;
        @(negedge ACLK); ARESET = 0;
        axi_write(256, 1, 4'h1, 0, 0);
        axi_read(256, 1, 0, 0);
        check_image("recover");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
